// File: rtl/voice_allocator.sv
// voice_allocator: schedules note-on/note-off events onto NUM_VOICES envelope voices.
// Define VOICE_STEAL_EN to steal a held voice (round-robin) when no free or releasing voice exists.
module voice_allocator #(
  parameter int NUM_VOICES = 8,
  parameter int NOTE_BITS = 7,
  parameter int IDX_BITS = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            note_on_valid,
  input  logic                            note_off_valid,
  input  logic [NOTE_BITS-1:0]            note,
  output logic                            ready,
  input  logic [NUM_VOICES-1:0]           voice_available,
  output logic [NUM_VOICES-1:0]           voice_en,
  output logic [NUM_VOICES*NOTE_BITS-1:0] voice_note,
  output logic                            alloc_valid,
  output logic [IDX_BITS-1:0]             alloc_idx,
  output logic                            steal
);
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_KILL, S_GRANT} state_t;
  typedef enum logic [1:0] {V_FREE, V_HELD, V_REL} vstat_t;
  state_t state, state_nx;
  vstat_t status [NUM_VOICES];
  logic [NOTE_BITS-1:0] vnote [NUM_VOICES];
  logic live, take_on, take_off;
  logic [NOTE_BITS-1:0] note_r;
  logic [IDX_BITS-1:0] tgt, pick, ia, ib, ic;
  logic steal_r, found, kill_pick, steal_pick, fa, fb, fc;
  assign take_off = ready && note_off_valid;
  assign take_on = ready && note_on_valid && !note_off_valid;
  // Descending scan leaves the lowest matching index in each candidate class.
  always_comb begin
    fa = 1'b0;
    fb = 1'b0;
    fc = 1'b0;
    ia = '0;
    ib = '0;
    ic = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (status[i] == V_HELD && vnote[i] == note_r) begin fa = 1'b1; ia = IDX_BITS'(i); end
      if (status[i] == V_FREE) begin fb = 1'b1; ib = IDX_BITS'(i); end
      if (status[i] == V_REL) begin fc = 1'b1; ic = IDX_BITS'(i); end
    end
  end
`ifdef VOICE_STEAL_EN
  logic [IDX_BITS-1:0] steal_ptr;
  assign steal_pick = !(fa || fb || fc);
  assign found = 1'b1;
  assign kill_pick = fa || steal_pick;
  assign pick = fa ? ia : fb ? ib : fc ? ic : steal_ptr;
  always_ff @(posedge clk or posedge rst)
    if (rst) steal_ptr <= '0;
    else if (state == S_SCAN && steal_pick)
      steal_ptr <= steal_ptr == IDX_BITS'(NUM_VOICES - 1) ? '0 : steal_ptr + IDX_BITS'(1);
`else
  assign steal_pick = 1'b0;
  assign found = fa || fb || fc;
  assign kill_pick = fa;
  assign pick = fa ? ia : fb ? ib : ic;
`endif
  always_comb begin
    state_nx = state;
    ready = live && state == S_IDLE;
    if (state == S_IDLE) state_nx = take_on ? S_SCAN : S_IDLE;
    else if (state == S_SCAN) state_nx = !found ? S_IDLE : kill_pick ? S_KILL : S_GRANT;
    else if (state == S_KILL) state_nx = S_GRANT;
    else state_nx = S_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      live <= 1'b0;
      note_r <= '0;
      tgt <= '0;
      steal_r <= 1'b0;
      alloc_valid <= 1'b0;
      alloc_idx <= '0;
      steal <= 1'b0;
    end else begin
      state <= state_nx;
      live <= 1'b1;
      alloc_valid <= state == S_GRANT;
      steal <= state == S_GRANT && steal_r;
      if (take_on) note_r <= note;
      if (state == S_SCAN) begin
        tgt <= pick;
        steal_r <= steal_pick;
      end
      if (state == S_GRANT) alloc_idx <= tgt;
    end
  // The grant commit outranks an available pulse arriving for the same voice.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        status[i] <= V_FREE;
        vnote[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_VOICES; i++)
        if (state == S_GRANT && tgt == IDX_BITS'(i)) begin
          status[i] <= V_HELD;
          vnote[i] <= note_r;
        end else if (take_off && status[i] == V_HELD && vnote[i] == note) status[i] <= V_REL;
        else if (status[i] == V_REL && voice_available[i]) status[i] <= V_FREE;
    end
  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
    assign voice_en[g] = status[g] == V_HELD && !(state == S_KILL && tgt == IDX_BITS'(g));
    assign voice_note[g*NOTE_BITS +: NOTE_BITS] = vnote[g];
  end
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: vector table, hand-written corner sequences and a randomized run against a voice-pool model.
module tb_voice_allocator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic note_on_valid = 1'b0;
  logic note_off_valid = 1'b0;
  logic [6:0] note = '0;
  logic ready;
  logic [7:0] voice_available = '0;
  logic [7:0] voice_en;
  logic [55:0] voice_note;
  logic alloc_valid;
  logic [2:0] alloc_idx;
  logic steal;
  int checks = 0;
  int errors = 0;

  voice_allocator dut (
    .clk(clk), .rst(rst), .note_on_valid(note_on_valid), .note_off_valid(note_off_valid),
    .note(note), .ready(ready), .voice_available(voice_available), .voice_en(voice_en),
    .voice_note(voice_note), .alloc_valid(alloc_valid), .alloc_idx(alloc_idx), .steal(steal)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // pool model: 0 free, 1 held, 2 releasing
  int mst [8];
  logic [6:0] mnt [8];
  int mptr;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      mst[i] = 0;
      mnt[i] = '0;
    end
    mptr = 0;
  endtask

  function automatic logic [7:0] model_en();
    logic [7:0] e = '0;
    for (int i = 0; i < 8; i++) e[i] = mst[i] == 1;
    return e;
  endfunction

  function automatic logic [55:0] model_notes();
    logic [55:0] v = '0;
    for (int i = 0; i < 8; i++) v[i*7 +: 7] = mnt[i];
    return v;
  endfunction

  // kind: 0 dropped, 1 retrigger, 2 free, 3 releasing, 4 steal
  task automatic model_pick(input logic [6:0] n, output int idx, output int kind);
    idx = 0;
    kind = 0;
    for (int i = 7; i >= 0; i--) if (mst[i] == 2) begin idx = i; kind = 3; end
    for (int i = 7; i >= 0; i--) if (mst[i] == 0) begin idx = i; kind = 2; end
    for (int i = 7; i >= 0; i--) if (mst[i] == 1 && mnt[i] == n) begin idx = i; kind = 1; end
`ifdef VOICE_STEAL_EN
    if (kind == 0) begin idx = mptr; kind = 4; end
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    note_on_valid = 1'b0;
    note_off_valid = 1'b0;
    voice_available = '0;
    @(posedge clk); #1;
    chk("rst_en", 64'(voice_en), 64'(0));
    chk("rst_note", 64'(voice_note), 64'(0));
    chk("rst_alloc", 64'({alloc_valid, alloc_idx, steal}), 64'(0));
    chk("rst_ready", 64'(ready), 64'(0));
    rst = 1'b0;
    #1;
    chk("ready_before_edge", 64'(ready), 64'(0));
    @(posedge clk); #1;
    chk("ready_after_edge", 64'(ready), 64'(1));
    model_clear();
  endtask

  task automatic wait_ready(input string name);
    int k = 0;
    while (!ready && k < 20) begin @(posedge clk); #1; k++; end
    if (k >= 20) chk(name, 64'(ready), 64'(1));
  endtask

  task automatic note_on(input logic [6:0] n, output int lat, output logic [7:0] dip, output int dcnt);
    logic [7:0] en0;
    note = n;
    note_on_valid = 1'b1;
    wait_ready("on_ready_timeout");
    en0 = voice_en;
    @(posedge clk); #1;
    note_on_valid = 1'b0;
    lat = 0;
    dip = '0;
    dcnt = 0;
    while (!alloc_valid && lat < 6) begin
      if (voice_en != en0) begin dip |= en0 & ~voice_en; dcnt++; end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic note_off(input logic [6:0] n);
    note = n;
    note_off_valid = 1'b1;
    wait_ready("off_ready_timeout");
    @(posedge clk); #1;
    note_off_valid = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] m);
    voice_available = m;
    @(posedge clk); #1;
    voice_available = '0;
  endtask

  typedef struct {
    int op;
    logic [7:0] val;
    logic [7:0] en;
    int idx;
    logic stl;
    int lat;
    logic [7:0] dip;
  } vec_t;
  vec_t vecs [16];

  int lat, dcnt, eidx, kind, r;
  logic [7:0] dip, m;
  logic [6:0] n;
  logic [55:0] exp_notes;

  initial begin
    vecs[0]  = '{0, 8'd60, 8'h01, 0, 1'b0, 2, 8'h00};
    vecs[1]  = '{0, 8'd62, 8'h03, 1, 1'b0, 2, 8'h00};
    vecs[2]  = '{0, 8'd64, 8'h07, 2, 1'b0, 2, 8'h00};
    vecs[3]  = '{1, 8'd62, 8'h05, 0, 1'b0, 0, 8'h00};
    vecs[4]  = '{2, 8'h02, 8'h05, 0, 1'b0, 0, 8'h00};
    vecs[5]  = '{0, 8'd67, 8'h07, 1, 1'b0, 2, 8'h00};
    vecs[6]  = '{0, 8'd64, 8'h07, 2, 1'b0, 3, 8'h04};
    vecs[7]  = '{1, 8'd60, 8'h06, 0, 1'b0, 0, 8'h00};
    vecs[8]  = '{0, 8'd61, 8'h0E, 3, 1'b0, 2, 8'h00};
    vecs[9]  = '{0, 8'd65, 8'h1E, 4, 1'b0, 2, 8'h00};
    vecs[10] = '{0, 8'd66, 8'h3E, 5, 1'b0, 2, 8'h00};
    vecs[11] = '{0, 8'd68, 8'h7E, 6, 1'b0, 2, 8'h00};
    vecs[12] = '{0, 8'd69, 8'hFE, 7, 1'b0, 2, 8'h00};
    vecs[13] = '{0, 8'd71, 8'hFF, 0, 1'b0, 2, 8'h00};
`ifdef VOICE_STEAL_EN
    vecs[14] = '{0, 8'd70, 8'hFF, 0, 1'b1, 3, 8'h01};
    vecs[15] = '{0, 8'd72, 8'hFF, 1, 1'b1, 3, 8'h02};
    exp_notes = {7'd69, 7'd68, 7'd66, 7'd65, 7'd61, 7'd64, 7'd72, 7'd70};
`else
    vecs[14] = '{0, 8'd70, 8'hFF, 0, 1'b0, 6, 8'h00};
    vecs[15] = '{0, 8'd72, 8'hFF, 0, 1'b0, 6, 8'h00};
    exp_notes = {7'd69, 7'd68, 7'd66, 7'd65, 7'd61, 7'd64, 7'd67, 7'd71};
`endif
    do_reset();
    for (int k = 0; k < 16; k++) begin
      if (vecs[k].op == 0) begin
        note_on(vecs[k].val[6:0], lat, dip, dcnt);
        chk($sformatf("vec%0d_lat", k), 64'(lat), 64'(vecs[k].lat));
        if (vecs[k].lat < 6) begin
          chk($sformatf("vec%0d_idx", k), 64'(alloc_idx), 64'(vecs[k].idx));
          chk($sformatf("vec%0d_steal", k), 64'(steal), 64'(vecs[k].stl));
          chk($sformatf("vec%0d_dip", k), 64'(dip), 64'(vecs[k].dip));
          chk($sformatf("vec%0d_dipcnt", k), 64'(dcnt), 64'(vecs[k].dip != 0));
        end
      end else if (vecs[k].op == 1) note_off(vecs[k].val[6:0]);
      else pulse(vecs[k].val);
      chk($sformatf("vec%0d_en", k), 64'(voice_en), 64'(vecs[k].en));
    end
    chk("table_notes", 64'(voice_note), 64'(exp_notes));

    // note-off wins over a simultaneous note-on, which is granted afterwards
    do_reset();
    note_on(7'd60, lat, dip, dcnt);
    note = 7'd60;
    note_on_valid = 1'b1;
    note_off_valid = 1'b1;
    wait_ready("both_ready_timeout");
    @(posedge clk); #1;
    chk("both_off_first_en", 64'(voice_en), 64'(0));
    chk("both_ready_kept", 64'(ready), 64'(1));
    note_off_valid = 1'b0;
    note_on(7'd61, lat, dip, dcnt);
    chk("both_on_lat", 64'(lat), 64'(2));
    chk("both_on_idx", 64'(alloc_idx), 64'(1));
    chk("both_on_en", 64'(voice_en), 64'(8'h02));

    // reset asserted while the retriggered voice sits in its kill cycle
    do_reset();
    note_on(7'd60, lat, dip, dcnt);
    note = 7'd60;
    note_on_valid = 1'b1;
    @(posedge clk); #1;
    note_on_valid = 1'b0;
    @(posedge clk); #1;
    chk("kill_en_low", 64'(voice_en), 64'(0));
    rst = 1'b1;
    #1;
    chk("midrst_en", 64'(voice_en), 64'(0));
    chk("midrst_alloc", 64'(alloc_valid), 64'(0));
    chk("midrst_ready", 64'(ready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_ready_low", 64'(ready), 64'(0));
    @(posedge clk); #1;
    chk("midrst_ready_high", 64'(ready), 64'(1));
    for (int k = 0; k < 4; k++) begin
      chk("midrst_no_grant", 64'({alloc_valid, voice_en}), 64'(0));
      @(posedge clk); #1;
    end

    // randomized traffic against the pool model
    do_reset();
    for (int t = 0; t < 400; t++) begin
      r = int'($urandom_range(0, 9));
      n = 7'(60 + $urandom_range(0, 7));
      if (r < 5) begin
        model_pick(n, eidx, kind);
        note_on(n, lat, dip, dcnt);
        if (kind == 0) chk("rnd_drop_lat", 64'(lat), 64'(6));
        else begin
          chk("rnd_lat", 64'(lat), 64'((kind == 1 || kind == 4) ? 3 : 2));
          chk("rnd_idx", 64'(alloc_idx), 64'(eidx));
          chk("rnd_steal", 64'(steal), 64'(kind == 4));
          chk("rnd_dip", 64'(dip), 64'((kind == 1 || kind == 4) ? (8'h01 << eidx) : 8'h00));
          mst[eidx] = 1;
          mnt[eidx] = n;
          if (kind == 4) mptr = (mptr + 1) % 8;
        end
      end else if (r < 8) begin
        note_off(n);
        for (int i = 0; i < 8; i++) if (mst[i] == 1 && mnt[i] == n) mst[i] = 2;
      end else begin
        m = 8'($urandom);
        pulse(m);
        for (int i = 0; i < 8; i++) if (mst[i] == 2 && m[i]) mst[i] = 0;
      end
      chk("rnd_en", 64'(voice_en), 64'(model_en()));
      chk("rnd_notes", 64'(voice_note), 64'(model_notes()));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Schedules note-on/note-off events onto a bank of NUM_VOICES rc_filter_fsm envelope generators.
- Drives each envelope's en input and records the note each voice plays.
- Uses each envelope's available pulse to reclaim voices.
- Sits between the MIDI/command decoder and the voice bank.

Parameters:
NUM_VOICES, 8, number of envelope/oscillator voices managed
NOTE_BITS, 7, width of the note number
IDX_BITS, 3, width of a voice index; must be at least clog2(NUM_VOICES)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
note_on_valid  in  1  note-on request; held until accepted
note_off_valid  in  1  note-off request; held until accepted
note  in  NOTE_BITS  note number for the current request
ready  out  1  allocator can accept a request this cycle
voice_available  in  NUM_VOICES  per-voice available pulse from the envelope bank
voice_en  out  NUM_VOICES  per-voice en to the envelope bank
voice_note  out  NUM_VOICES*NOTE_BITS  note held per voice; voice i at bits [i*NOTE_BITS +: NOTE_BITS]
alloc_valid  out  1  one-cycle pulse: a note-on has been granted
alloc_idx  out  IDX_BITS  granted voice index; valid with alloc_valid
steal  out  1  one-cycle pulse with alloc_valid when the grant evicted a HELD voice

Behaviour:
- Reset (async, rst=1):
  - voice_en=0, voice_note=0, alloc_valid=0, alloc_idx=0, steal=0, ready=0.
  - All voices FREE, steal_ptr=0, FSM in S_IDLE.
  - ready rises on the first clk edge after rst falls.
- Per-voice status, 2 bits each:
  - FREE: en=0, envelope idle.
  - HELD: en=1.
  - RELEASING: en=0, waiting for the available pulse.
  - voice_available[i] moves RELEASING to FREE.
  - voice_available[i] is ignored in FREE and HELD.
- Acceptance, only when ready=1 (S_IDLE):
  - note_off_valid has priority over note_on_valid when both are high.
  - An un-accepted note-on stays pending; the requester keeps it asserted.
  - Accepted: note_off_valid&ready, or note_on_valid&~note_off_valid&ready.
- Note-off, single cycle, stays in S_IDLE with ready high:
  - Every HELD voice with voice_note==note goes RELEASING and its en drops next cycle.
  - No match: no effect.
- Note-on FSM: S_IDLE -> S_SCAN -> [S_KILL] -> S_GRANT -> S_IDLE. ready=0 outside S_IDLE.
  - S_SCAN picks the target in priority order:
    (a) lowest-index HELD voice with the same note (retrigger);
    (b) lowest-index FREE voice;
    (c) lowest-index RELEASING voice;
    (d) steal the voice at steal_ptr, then steal_ptr increments modulo NUM_VOICES.
  - Retrigger of a HELD voice and steal of a HELD voice both go to S_KILL.
  - S_KILL: target en=0 for exactly one cycle, so the envelope enters release.
  - S_GRANT:
    - target en=1 and voice_note=note; status becomes HELD.
    - alloc_valid=1 and alloc_idx=target.
    - steal=1 only for case (d).
  - Latency from the accept edge to alloc_valid: 2 cycles for FREE/RELEASING targets, 3 cycles via S_KILL.
- Simultaneous events:
  - voice_available for the target in S_GRANT: the grant wins and the voice ends HELD.
  - voice_available for other voices is honoured in every state.
- Width rules:
  - note is latched at accept.
  - alloc_idx is zero-extended when NUM_VOICES < 2^IDX_BITS.
- rst asserted mid-sequence: immediate return to reset values; no partial grant is emitted.

Optional Feature:
- Macro VOICE_STEAL_EN.
- Defined: case (d) is active, as described above.
- Undefined:
  - When no FREE or RELEASING voice exists and no retrigger matches, the note-on is accepted and dropped.
  - FSM returns S_SCAN -> S_IDLE.
  - alloc_valid and steal stay 0; steal_ptr is not implemented.
  - Cases (a)-(c) are unchanged.

Test Plan:
- Reset, then note_on note=60 -> alloc_valid 2 cycles after accept, alloc_idx=0, voice_en=8'b0000_0001, voice_note[0]=60, steal=0.
- Note-ons 60,62,64 then note_off 62 -> voice_en=8'b0000_0101; pulse voice_available[1] -> voice 1 FREE; next note_on 67 -> alloc_idx=1.
- Fill all 8 voices with notes 60..67, then note_on 70:
  - With VOICE_STEAL_EN: voice_en[0] low one cycle, alloc_valid 3 cycles after accept, alloc_idx=0, steal=1, voice_note[0]=70; next steal targets index 1.
  - Without VOICE_STEAL_EN: no alloc_valid, voice_en stays 8'hFF.
- note_on 60 while voice 3 holds 60 -> voice_en[3] low one cycle, alloc_idx=3, steal=0.
- note_on_valid and note_off_valid both high (off=60, on=61) -> note-off handled first; note-on granted afterwards while note_on_valid stays high.
- Assert rst during S_KILL -> voice_en=0, alloc_valid=0, ready=0 immediately; ready=1 one cycle after release.
